// File: rtl/patch_reducer_scheduler_pkg.sv
// Shared definitions for the patch reducer scheduler: FSM state encodings and
// the index-width helper used to size reducer indices.
package patch_reducer_scheduler_pkg;

    typedef enum logic {
        ALLOC_IDLE,
        ALLOC_SETTLE
    } alloc_state_e;

    typedef enum logic [1:0] {
        COL_IDLE,
        COL_HOLD,
        COL_ACK
    } col_state_e;

    // Never returns 0 so that a single-reducer build still gets a 1-bit index.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/patch_reducer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// the pointer, wrapping cyclically, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (32'(ptr_i) + 32'(k)) % 32'(N);
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o                = 1'b1;
                idx_o                  = IDX_W'(cand);
                grant_o[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/patch_reducer_scheduler.sv
// Hands patch requests to idle reducers (allocator) and drains finished
// reducer sums one at a time to a ready/valid output (collector).
module patch_reducer_scheduler
    import patch_reducer_scheduler_pkg::*;
#(
    parameter int N_REDUCER  = 4,
    parameter int N_ROW_SIZE = 11,
    parameter int PATCH_SIZE = 6,
    parameter int FP_SIZE    = 32
) (
    input  logic                            dram_clk,
    input  logic                            reset,
    input  logic                            patch_req,
    input  logic [N_ROW_SIZE-1:0]           patch_start_row,
    output logic                            patch_ack,
    input  logic [N_REDUCER-1:0]            reducer_available,
    output logic [N_REDUCER-1:0]            reducer_init,
    output logic [N_ROW_SIZE-1:0]           reducer_start_row,
    input  logic [N_REDUCER-1:0]            reducer_sum_rdy,
    input  logic [N_REDUCER*FP_SIZE-1:0]    reducer_sum,
    input  logic [N_REDUCER*N_ROW_SIZE-1:0] reducer_current_row,
    output logic [N_REDUCER-1:0]            reducer_sum_ack,
    output logic                            sum_valid,
    input  logic                            sum_ready,
    output logic [FP_SIZE-1:0]              sum,
    output logic [N_ROW_SIZE-1:0]           sum_row,
    output logic [log2(N_REDUCER)-1:0]      sum_id,
    output logic                            full
);

    localparam int IDX_W = log2(N_REDUCER);

    if (PATCH_SIZE < 1 || PATCH_SIZE > (1 << N_ROW_SIZE)) begin : g_patch_size_check
        $error("PATCH_SIZE does not fit in the row index range");
    end

    alloc_state_e            alloc_state_q;
    logic                    patch_ack_q;
    logic [N_REDUCER-1:0]    reducer_init_q;
    logic [N_ROW_SIZE-1:0]   start_row_q;
    logic [N_REDUCER-1:0]    alloc_grant_d;

    col_state_e              col_state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic                    sum_valid_q;
    logic [FP_SIZE-1:0]      sum_q;
    logic [N_ROW_SIZE-1:0]   sum_row_q;
    logic [IDX_W-1:0]        sum_id_q;
    logic [N_REDUCER-1:0]    grant_q;
    logic [N_REDUCER-1:0]    sum_ack_q;

    logic [N_REDUCER-1:0]    arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;
    logic [FP_SIZE-1:0]      sel_sum;
    logic [N_ROW_SIZE-1:0]   sel_row;

    // Isolate the lowest set availability bit.
    assign alloc_grant_d = reducer_available & (~reducer_available + N_REDUCER'(1));

    // The SETTLE cycle gives a just-initialised reducer time to drop its
    // available flag before the allocator looks at the vector again.
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            alloc_state_q  <= ALLOC_IDLE;
            patch_ack_q    <= 1'b0;
            reducer_init_q <= '0;
            start_row_q    <= '0;
        end else begin
            case (alloc_state_q)
                ALLOC_IDLE: begin
                    patch_ack_q    <= 1'b0;
                    reducer_init_q <= '0;
                    if (patch_req && (|reducer_available)) begin
                        patch_ack_q    <= 1'b1;
                        reducer_init_q <= alloc_grant_d;
                        start_row_q    <= patch_start_row;
                        alloc_state_q  <= ALLOC_SETTLE;
                    end
                end
                default: begin
                    patch_ack_q    <= 1'b0;
                    reducer_init_q <= '0;
                    alloc_state_q  <= ALLOC_IDLE;
                end
            endcase
        end
    end

    rr_arbiter #(
        .N     (N_REDUCER),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (reducer_sum_rdy),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_sum = '0;
        sel_row = '0;
        for (int i = 0; i < N_REDUCER; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_sum = reducer_sum[i*FP_SIZE +: FP_SIZE];
                sel_row = reducer_current_row[i*N_ROW_SIZE +: N_ROW_SIZE];
            end
        end
    end

    // The pointer only advances once the result has actually been accepted,
    // so a stalled downstream never lets a later reducer jump the queue.
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            col_state_q <= COL_IDLE;
            rr_ptr_q    <= IDX_W'(N_REDUCER - 1);
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
            sum_row_q   <= '0;
            sum_id_q    <= '0;
            grant_q     <= '0;
            sum_ack_q   <= '0;
        end else begin
            case (col_state_q)
                COL_IDLE: begin
                    sum_ack_q <= '0;
                    if (arb_valid) begin
                        sum_q       <= sel_sum;
                        sum_row_q   <= sel_row;
                        sum_id_q    <= arb_idx;
                        grant_q     <= arb_grant;
                        sum_valid_q <= 1'b1;
                        col_state_q <= COL_HOLD;
                    end
                end
                COL_HOLD: begin
                    if (sum_ready) begin
                        sum_valid_q <= 1'b0;
                        sum_ack_q   <= grant_q;
                        rr_ptr_q    <= sum_id_q;
                        col_state_q <= COL_ACK;
                    end
                end
                default: begin
                    sum_ack_q   <= '0;
                    col_state_q <= COL_IDLE;
                end
            endcase
        end
    end

    assign patch_ack         = patch_ack_q;
    assign reducer_init      = reducer_init_q;
    assign reducer_start_row = start_row_q;
    assign reducer_sum_ack   = sum_ack_q;
    assign sum_valid         = sum_valid_q;
    assign sum               = sum_q;
    assign sum_row           = sum_row_q;
    assign sum_id            = sum_id_q;
    assign full              = ~|reducer_available;

endmodule

// File: doc/patch_reducer_scheduler.md
PATCH_REDUCER_SCHEDULER -- requirements
Module: patch_reducer_scheduler

Interface
REQ-001 SHALL take parameters: N_REDUCER, default 4, number of reducers; N_ROW_SIZE, default 11, row index width; PATCH_SIZE, default 6, rows per patch; FP_SIZE, default 32, float width.
REQ-002 SHALL have ports:
- dram_clk  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- patch_req  in  1  request to start a patch.
- patch_start_row  in  N_ROW_SIZE  first row of the requested patch.
- patch_ack  out  1  one-cycle pulse: request consumed.
- reducer_available  in  N_REDUCER  per-reducer idle flag.
- reducer_init  out  N_REDUCER  one-hot, one-cycle init pulse.
- reducer_start_row  out  N_ROW_SIZE  start row, shared by all reducers.
- reducer_sum_rdy  in  N_REDUCER  per-reducer result-ready flag.
- reducer_sum  in  N_REDUCER*FP_SIZE  packed sums; reducer i at [i*FP_SIZE +: FP_SIZE].
- reducer_current_row  in  N_REDUCER*N_ROW_SIZE  packed start rows, same packing.
- reducer_sum_ack  out  N_REDUCER  one-hot, one-cycle ack pulse.
- sum_valid  out  1  result presented.
- sum_ready  in  1  downstream accepts.
- sum  out  FP_SIZE  selected sum.
- sum_row  out  N_ROW_SIZE  start row of that patch.
- sum_id  out  log2(N_REDUCER)  reducer index.
- full  out  1  combinational ~|reducer_available.

Function
REQ-003 SHALL run the allocator FSM ALLOC_IDLE/ALLOC_SETTLE.
- ALLOC_IDLE, patch_req=1 and any reducer_available bit set: select lowest set index i; next edge sets reducer_init[i]=1, patch_ack=1, reducer_start_row=patch_start_row; go to ALLOC_SETTLE.
- ALLOC_SETTLE: clear reducer_init and patch_ack; return to ALLOC_IDLE.
REQ-004 SHALL perform no allocation in ALLOC_SETTLE, so a just-initialised reducer whose available flag is still high is never selected twice; maximum rate is one allocation per 2 cycles.
REQ-005 SHALL, for patch_req=1 with reducer_available=0, hold ALLOC_IDLE with no ack indefinitely; the requester holds patch_req and patch_start_row until patch_ack.
REQ-006 SHALL treat patch_req sampled in the patch_ack cycle as a new request.
REQ-007 SHALL run the collector FSM COL_IDLE/COL_HOLD/COL_ACK.
- COL_IDLE, any reducer_sum_rdy set: grant g = first set index after rr_ptr, cyclic; register sum, sum_row and sum_id=g from reducer g; set sum_valid=1; go to COL_HOLD.
- COL_HOLD, sum_ready=1: next edge clears sum_valid, pulses reducer_sum_ack[g], sets rr_ptr=g; go to COL_ACK.
- COL_ACK: clear reducer_sum_ack; return to COL_IDLE.
REQ-008 SHALL hold sum, sum_row and sum_id stable while sum_valid=1 and sum_ready=0.
REQ-009 SHALL sustain at most one result per 3 cycles with sum_ready tied high.
REQ-010 SHALL run allocator and collector independently; both may pulse in the same cycle.
REQ-011 SHALL have a 1-cycle latency from sum_rdy sampled in COL_IDLE to sum_valid.

Reset
REQ-012 SHALL, on reset, asynchronously clear patch_ack, reducer_init, reducer_sum_ack, sum_valid, sum, sum_row, sum_id and reducer_start_row to 0, set both FSMs to their IDLE state, and set rr_ptr=N_REDUCER-1 so the first grant is index 0.
REQ-013 SHALL, when reset is asserted mid-operation (any state), abandon in-flight grants without emitting an ack; reducers share the same reset.

Structure
REQ-014 SHALL place FSM state encodings and the shared log2 function in the common include/package; parameters stay module-local.
REQ-015 SHALL instantiate exactly one sub-module, rr_arbiter (request vector plus pointer in, one-hot grant plus index out, combinational), used by the collector; the allocator uses a fixed lowest-index priority encoder inline.

Verification
REQ-016 SHALL pass these directed scenarios, with N_REDUCER=4:
- Reset with available=1111 -> all outputs 0, full=0; available=0000 -> full=1.
- available=1111, patch_req with start_row=100 -> next cycle init=0001, reducer_start_row=100, patch_ack=1; following cycle init=0000. Second request with available=1110 -> init=0010.
- available=0000, patch_req held 10 cycles -> no ack; raise available[2] -> next cycle init=0100 and ack.
- sum_rdy=1111 with sums 1.0, 2.0, 3.0, 4.0 and sum_ready high -> results emerge ids 0,1,2,3 in order, 3 cycles apart, each with a matching one-hot sum_ack.
- sum_ready low 5 cycles during COL_HOLD -> sum_valid stays 1, sum stable, no ack; sum_ready high -> one ack pulse.
- reset asserted in COL_HOLD and ALLOC_SETTLE -> sum_valid, init and acks 0 immediately; first post-reset grant is index 0.
